// File: rtl/serial_port.sv
// UART with transmitter, receiver and a small RX buffer; frame = start, DATA_BITS LSB-first, optional parity, STOP_BITS.
// Latency: TX frame starts the clock after an accepted strobe; RX entry is visible 1 clock after the stop-bit sample.
// Backpressure: tx_busy/tx_block hold off new TX frames; RX pops on rx_valid & rx_ready, a frame arriving to a full FIFO is dropped and flagged in rx_overflow.
//
// Ports:
//   clk, rst (async, active-high)   rx / tx serial pins (tx idles high)
//   tx_data, new_tx_data, tx_block, tx_busy     transmit side
//   rx_data, rx_valid, rx_ready, rx_parity_err, rx_frame_err, rx_overflow     receive FIFO head
module serial_port #(
    parameter int CLK_RATE         = 50000000,
    parameter int SERIAL_BAUD_RATE = 500000,
    parameter int DATA_BITS        = 8,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1,
    parameter int RX_FIFO_DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 new_tx_data,
    input  logic                 tx_block,
    output logic                 tx_busy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overflow
);

    localparam int CLK_PER_BIT = (CLK_RATE + SERIAL_BAUD_RATE - 1) / SERIAL_BAUD_RATE;
    localparam int HALF_BIT    = (CLK_PER_BIT / 2 > 0) ? CLK_PER_BIT / 2 : 1;
    localparam int STOP_CLKS   = STOP_BITS * CLK_PER_BIT;
    localparam int CW          = $clog2(STOP_CLKS + 1);
    localparam int BW          = $clog2(DATA_BITS);
    localparam int AW          = $clog2(RX_FIFO_DEPTH);
    localparam int EW          = DATA_BITS + 2;

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CLKS - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic          ODD       = (PARITY == 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    // ---------------------------------------------------------------- TX
    state_t                 tx_state, tx_state_nxt;
    logic [CW-1:0]          tx_cnt;
    logic [BW-1:0]          tx_bit;
    logic [DATA_BITS-1:0]   tx_shift;
    logic                   tx_par;
    logic                   tx_accept;
    logic                   tx_cnt_done;

    // rst is folded in so the port reads busy for the whole reset window.
    assign tx_busy     = rst | (tx_state != S_IDLE) | tx_block;
    assign tx_accept   = (tx_state == S_IDLE) & new_tx_data & ~tx_busy;
    assign tx_cnt_done = (tx_state == S_STOP) ? (tx_cnt == STOP_LAST) : (tx_cnt == BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_state <= S_IDLE;
        else     tx_state <= tx_state_nxt;
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx           = 1'b1;
        case (tx_state)
            S_IDLE:  if (tx_accept) tx_state_nxt = S_START;
            S_START: begin
                tx = 1'b0;
                if (tx_cnt_done) tx_state_nxt = S_DATA;
            end
            S_DATA: begin
                tx = tx_shift[0];
                if (tx_cnt_done && tx_bit == DATA_LAST)
                    tx_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
            end
            S_PAR: begin
                tx = tx_par;
                if (tx_cnt_done) tx_state_nxt = S_STOP;
            end
            S_STOP:  if (tx_cnt_done) tx_state_nxt = S_IDLE;
            default: tx_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
        end else begin
            if (tx_state == S_IDLE || tx_cnt_done) tx_cnt <= '0;
            else                                   tx_cnt <= tx_cnt + 1'b1;

            if (tx_accept) begin
                tx_shift <= tx_data;
                tx_par   <= ^tx_data ^ ODD;
                tx_bit   <= '0;
            end else if (tx_state == S_DATA && tx_cnt_done) begin
                tx_shift <= tx_shift >> 1;
                tx_bit   <= tx_bit + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- RX
    logic [1:0]             rx_sync;
    logic                   rx_s, rx_prev;
    state_t                 rx_state, rx_state_nxt;
    logic [CW-1:0]          rx_cnt;
    logic [BW-1:0]          rx_bit;
    logic [DATA_BITS-1:0]   rx_shift;
    logic                   rx_par_smp;
    logic                   rx_tick;
    logic                   rx_push;
    logic                   rx_par_bad;
    logic [EW-1:0]          rx_word;

    // Synchroniser presets to the idle level so reset release never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], rx};
            rx_prev <= rx_sync[1];
        end
    end
    assign rx_s = rx_sync[1];

    // START waits half a bit; every later sample is one full bit on, landing mid-bit.
    assign rx_tick = (rx_state == S_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state <= S_IDLE;
        else     rx_state <= rx_state_nxt;
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_push      = 1'b0;
        case (rx_state)
            S_IDLE:  if (rx_prev && !rx_s) rx_state_nxt = S_START;
            S_START: if (rx_tick) rx_state_nxt = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (rx_tick && rx_bit == DATA_LAST)
                         rx_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:   if (rx_tick) rx_state_nxt = S_STOP;
            S_STOP:  if (rx_tick) begin
                         // Only the first stop bit is checked; leaving now lets the next start edge be caught.
                         rx_state_nxt = S_IDLE;
                         rx_push      = 1'b1;
                     end
            default: rx_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_par_smp <= 1'b0;
        end else begin
            if (rx_state == S_IDLE || rx_tick) rx_cnt <= '0;
            else                               rx_cnt <= rx_cnt + 1'b1;

            if (rx_state == S_IDLE) rx_bit <= '0;
            if (rx_state == S_DATA && rx_tick) begin
                rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
            if (rx_state == S_PAR && rx_tick) rx_par_smp <= rx_s;
        end
    end

    assign rx_par_bad = (PARITY != 0) && (rx_par_smp != (^rx_shift ^ ODD));
    assign rx_word    = {rx_par_bad, ~rx_s, rx_shift};

    // ---------------------------------------------------------------- RX FIFO
    logic [EW-1:0]  mem [RX_FIFO_DEPTH];
    logic [AW:0]    wr_ptr, rd_ptr;
    logic           fifo_full, fifo_empty;
    logic           pop, push_ok;
    logic [EW-1:0]  head;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = rx_valid & rx_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok    = rx_push & (~fifo_full | pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (rx_push && !push_ok) rx_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= rx_word;
    end

    // Head is gated with valid so stale storage never shows on the outputs.
    assign head          = mem[rd_ptr[AW-1:0]];
    assign rx_valid      = ~fifo_empty;
    assign rx_data       = rx_valid ? head[DATA_BITS-1:0] : '0;
    assign rx_frame_err  = rx_valid & head[DATA_BITS];
    assign rx_parity_err = rx_valid & head[DATA_BITS+1];

endmodule
